// File: rtl/ser_tx_if.sv
// Byte handshake between a producer and the serial transmitter's input FIFO.
interface ser_tx_if;
    logic [7:0] din;
    logic       din_vld;
    logic       din_rdy;

    modport master (output din, output din_vld, input din_rdy);
    modport slave  (input din, input din_vld, output din_rdy);
endinterface

// File: rtl/ser_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte input into a circular FIFO,
// LSB-first serial output with one start and one stop bit, back-to-back frames.
module ser_tx_fifo #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned ADDR_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    ser_tx_if.slave         tx,
    output logic            ser_txd,
    output logic            busy,
    output logic [ADDR_W:0] fifo_cnt
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              push;
    logic              pop;
    logic              cnt_nz;
    logic              baud_end;

    logic [1:0]        state, state_nxt;
    logic [BAUD_W-1:0] baud_cnt, baud_nxt;
    logic [2:0]        bit_cnt, bit_nxt;
    logic [7:0]        sr, sr_nxt;
    logic              txd_nxt;
    logic              busy_nxt;

    // No bypass: a pop on the same edge does not reopen a full FIFO.
    assign full        = (fifo_cnt == CNT_W'(DEPTH));
    assign tx.din_rdy  = ~full;
    assign push        = tx.din_vld & ~full;
    assign cnt_nz      = (fifo_cnt != '0);
    assign baud_end    = (baud_cnt == BAUD_W'(CLK_DIV - 1));

    // Storage needs no reset; pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            ser_txd  <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            sr       <= sr_nxt;
            ser_txd  <= txd_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        sr_nxt    = sr;
        txd_nxt   = ser_txd;
        busy_nxt  = busy;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                if (cnt_nz) begin
                    pop       = 1'b1;
                    sr_nxt    = mem[rd_ptr];
                    txd_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                    baud_nxt  = '0;
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_nxt  = '0;
                    txd_nxt   = sr[0];
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == 3'd7) begin
                        txd_nxt   = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        sr_nxt  = {1'b0, sr[7:1]};
                        txd_nxt = sr[1];
                        bit_nxt = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                // Stop bit end chains straight into the next start bit when data waits.
                if (baud_end) begin
                    baud_nxt = '0;
                    if (cnt_nz) begin
                        pop       = 1'b1;
                        sr_nxt    = mem[rd_ptr];
                        txd_nxt   = 1'b0;
                        state_nxt = S_START;
                    end else begin
                        busy_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
        endcase
    end

endmodule

// File: tb/tb_ser_tx_fifo.sv
// Directed bench for ser_tx_fifo: scoreboard of queued bytes against a
// serial-line decoder, plus cycle-exact line, count and handshake checks.
module tb_ser_tx_fifo;

    localparam int DIV  = 4;
    localparam int HALF = DIV / 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_txd;
    logic       busy;
    logic [2:0] fifo_cnt;

    ser_tx_if bus ();

    ser_tx_fifo #(.CLK_DIV(DIV), .ADDR_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx       (bus),
        .ser_txd  (ser_txd),
        .busy     (busy),
        .fifo_cnt (fifo_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int frames      = 0;

    logic [7:0] sb [$];
    int         starts [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line decoder: samples mid-bit on the falling clock, aborts on reset.
    logic       dec_busy = 1'b0;
    int         dec_t    = 0;
    logic [7:0] dec_byte = '0;
    logic [7:0] exp_byte;

    always @(negedge clk) begin
        if (rst) begin
            dec_busy = 1'b0;
        end else if (!dec_busy) begin
            if (ser_txd === 1'b0) begin
                dec_busy = 1'b1;
                dec_t    = 0;
                starts.push_back(cyc);
            end
        end else begin
            dec_t++;
        end
        if (dec_busy && !rst) begin
            if (dec_t == HALF) begin
                check("start_bit", 32'(ser_txd), 32'(0));
            end else if (dec_t > HALF && dec_t < HALF + 9 * DIV && (dec_t - HALF) % DIV == 0) begin
                dec_byte = {ser_txd, dec_byte[7:1]};
            end else if (dec_t == HALF + 9 * DIV) begin
                check("stop_bit", 32'(ser_txd), 32'(1));
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_frame: observed %02h expected none", dec_byte);
                end else begin
                    exp_byte = sb.pop_front();
                    check("frame_byte", 32'(dec_byte), 32'(exp_byte));
                end
                frames++;
                dec_busy = 1'b0;
            end
        end
    end

    logic [7:0] burst [5] = '{8'hA1, 8'h02, 8'h03, 8'h04, 8'h05};
    logic [9:0] fr;
    int         frames_before;

    initial begin
        rst         = 1'b1;
        bus.din     = '0;
        bus.din_vld = 1'b0;

        // Reset and idle line
        repeat (3) tick();
        check("rst_txd", 32'(ser_txd), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cnt", 32'(fifo_cnt), 32'(0));
        check("rst_rdy", 32'(bus.din_rdy), 32'(1));
        rst = 1'b0;
        repeat (10) tick();
        check("idle_txd", 32'(ser_txd), 32'(1));
        check("idle_busy", 32'(busy), 32'(0));

        // Single byte 0x55, cycle-exact waveform
        bus.din     = 8'h55;
        bus.din_vld = 1'b1;
        sb.push_back(8'h55);
        tick();
        bus.din_vld = 1'b0;
        check("push_cnt", 32'(fifo_cnt), 32'(1));
        check("push_txd", 32'(ser_txd), 32'(1));
        tick();
        check("pop_cnt", 32'(fifo_cnt), 32'(0));
        check("pop_busy", 32'(busy), 32'(1));
        fr = {1'b1, 8'h55, 1'b0};
        for (int j = 0; j < 10 * DIV; j++) begin
            check("wave_55", 32'(ser_txd), 32'(fr[j / DIV]));
            tick();
        end
        check("busy_fall", 32'(busy), 32'(0));
        check("end_txd", 32'(ser_txd), 32'(1));
        check("frames_55", 32'(frames), 32'(1));

        // Burst of 5 through a 4-deep FIFO, pointer wrap
        for (int i = 0; i < 5; i++) begin
            bus.din     = burst[i];
            bus.din_vld = 1'b1;
            check("burst_rdy", 32'(bus.din_rdy), 32'(1));
            sb.push_back(burst[i]);
            tick();
        end
        bus.din_vld = 1'b0;
        check("full_cnt", 32'(fifo_cnt), 32'(4));
        check("full_rdy", 32'(bus.din_rdy), 32'(0));

        // Push attempt on the pop edge while full must be dropped
        repeat (36) tick();
        check("prepop_cnt", 32'(fifo_cnt), 32'(4));
        check("prepop_rdy", 32'(bus.din_rdy), 32'(0));
        bus.din     = 8'hEE;
        bus.din_vld = 1'b1;
        tick();
        bus.din_vld = 1'b0;
        check("postpop_cnt", 32'(fifo_cnt), 32'(3));
        check("postpop_rdy", 32'(bus.din_rdy), 32'(1));
        check("no_gap_txd", 32'(ser_txd), 32'(0));

        for (int k = 0; k < 1000 && (sb.size() != 0 || busy); k++) tick();
        repeat (4) tick();
        check("drain_sb", 32'(sb.size()), 32'(0));
        check("drain_busy", 32'(busy), 32'(0));
        check("drain_cnt", 32'(fifo_cnt), 32'(0));
        check("frames_burst", 32'(frames), 32'(6));
        check("starts_size", 32'(starts.size()), 32'(6));
        if (starts.size() == 6) begin
            for (int i = 1; i < 5; i++) begin
                check("frame_spacing", 32'(starts[i + 1] - starts[i]), 32'(10 * DIV));
            end
        end

        // Reset during data bit 3 of 0xF0 with two bytes queued
        frames_before = frames;
        bus.din       = 8'hF0;
        bus.din_vld   = 1'b1;
        tick();
        bus.din = 8'h11;
        tick();
        bus.din = 8'h22;
        tick();
        bus.din_vld = 1'b0;
        repeat (15) tick();
        check("mid_cnt", 32'(fifo_cnt), 32'(2));
        check("mid_busy", 32'(busy), 32'(1));
        check("mid_bit3", 32'(ser_txd), 32'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_txd", 32'(ser_txd), 32'(1));
        check("abort_cnt", 32'(fifo_cnt), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_rdy", 32'(bus.din_rdy), 32'(1));
        repeat (100) tick();
        check("quiet_txd", 32'(ser_txd), 32'(1));
        check("quiet_busy", 32'(busy), 32'(0));
        check("quiet_frames", 32'(frames), 32'(frames_before));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
